// File: rtl/clk_div_monitor.sv
// -----------------------------------------------------------------------------
// clk_div_monitor
//
// Single-shot period / high-time meter for a slow periodic signal (typically
// the output of the clock divider). The signal is synchronised into the clk
// domain and edge-detected. One measurement is armed per start pulse. The
// result is then offered over a valid/ready handshake.
//
// Optional feature macro: CLK_DIV_MON_TIMEOUT_EN
//   defined   : ARM also counts, and gives up with ovf=1 when the counter
//               saturates before any rising edge is seen.
//   undefined : ARM waits for a rising edge indefinitely.
//
// Parameters
//   CNT_W        width of the counter and of the period/high_time results
//   SYNC_STAGES  synchroniser depth on sig_in (2 or more)
//
// Ports
//   clk         in   sampling clock, all logic on posedge
//   rst         in   asynchronous active-high reset
//   start       in   one-cycle arm request, honoured only in IDLE
//   sig_in      in   asynchronous signal under test
//   busy        out  high while ARM, HIGH or LOW
//   meas_valid  out  result available (DONE state)
//   meas_ready  in   consumer accepts the result
//   period      out  cycles between consecutive sampled rising edges
//   high_time   out  cycles from sampled rising to sampled falling edge
//   ovf         out  measurement aborted (saturation or timeout)
//   dbg_state   out  current FSM state encoding, for observation only
//
// Handshake: meas_valid is asserted in DONE and held, with period,
// high_time and ovf stable, until a cycle where meas_valid & meas_ready are
// both high. That cycle is the transfer. meas_valid is low from the next
// cycle. meas_ready has no effect while meas_valid is low.
// -----------------------------------------------------------------------------
module clk_div_monitor #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sig_in,
   output logic             busy,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             ovf,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARM  = 3'd1,
      S_HIGH = 3'd2,
      S_LOW  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t               state;
   state_t               state_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                 s;
   logic                 s_d;
   logic                 rise;
   logic                 fall;
   logic [CNT_W-1:0]     cnt;
   logic                 cnt_at_max;

   // ---------------------------------------------------------------
   // Synchroniser and edge detection
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         s_d    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         s_d    <= sync_q[SYNC_STAGES-1];
      end
   end

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~s_d;
   assign fall = ~s & s_d;

   assign cnt_at_max = (cnt == CNT_MAX);

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // ---------------------------------------------------------------
   // FSM: next state
   // Saturation is tested before edges in HIGH/LOW. This means an edge that
   // coincides with an all-ones count still reports an overflow, and the
   // counter never wraps into the next phase.
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = S_ARM;
         S_ARM: begin
            if (rise) state_nxt = S_HIGH;
`ifdef CLK_DIV_MON_TIMEOUT_EN
            else if (cnt_at_max) state_nxt = S_DONE;
`endif
         end
         S_HIGH: begin
            if (cnt_at_max) state_nxt = S_DONE;
            else if (fall)  state_nxt = S_LOW;
         end
         S_LOW: begin
            if (cnt_at_max) state_nxt = S_DONE;
            else if (rise)  state_nxt = S_DONE;
         end
         S_DONE: if (meas_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------
   always_comb begin
      busy       = 1'b0;
      meas_valid = 1'b0;
      case (state)
         S_ARM, S_HIGH, S_LOW: busy       = 1'b1;
         S_DONE:               meas_valid = 1'b1;
         default: ;
      endcase
   end

   assign dbg_state = state;

   // ---------------------------------------------------------------
   // Counter and result registers
   // cnt is 1 in the cycle after the rise. This makes the value present in
   // the fall (or next rise) cycle equal to the distance from the rise.
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         period    <= '0;
         high_time <= '0;
         ovf       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: cnt <= '0;
            S_ARM: begin
               if (rise) begin
                  cnt <= CNT_ONE;
               end
`ifdef CLK_DIV_MON_TIMEOUT_EN
               else if (cnt_at_max) begin
                  period    <= CNT_MAX;
                  high_time <= CNT_MAX;
                  ovf       <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
`endif
            end
            S_HIGH: begin
               if (cnt_at_max) begin
                  period    <= CNT_MAX;
                  high_time <= CNT_MAX;
                  ovf       <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
                  if (fall) high_time <= cnt;
               end
            end
            S_LOW: begin
               if (cnt_at_max) begin
                  // high_time keeps the value latched at the fall
                  period <= CNT_MAX;
                  ovf    <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
                  if (rise) begin
                     period <= cnt;
                     ovf    <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_clk_div_monitor.sv
// -----------------------------------------------------------------------------
// Testbench for clk_div_monitor.
// Two instances: a default CNT_W=16 instance for the normal measurements,
// and a CNT_W=4 instance that exercises saturation.
// Expected results are pushed to exp_q when a measurement is started. They
// are popped and compared when the result is transferred.
// -----------------------------------------------------------------------------
module tb_clk_div_monitor;

   localparam int CNT_W = 16;
   localparam int W     = 2 * CNT_W + 1;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOW  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT (CNT_W = 16) ----------------
   logic             start;
   logic             sig_in;
   logic             busy;
   logic             meas_valid;
   logic             meas_ready;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             ovf;
   logic [2:0]       dbg_state;

   clk_div_monitor #(.CNT_W(CNT_W), .SYNC_STAGES(2)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .sig_in     (sig_in),
      .busy       (busy),
      .meas_valid (meas_valid),
      .meas_ready (meas_ready),
      .period     (period),
      .high_time  (high_time),
      .ovf        (ovf),
      .dbg_state  (dbg_state)
   );

   // ---------------- DUT (CNT_W = 4) ----------------
   logic       start4;
   logic       sig_in4;
   logic       busy4;
   logic       valid4;
   logic       ready4;
   logic [3:0] period4;
   logic [3:0] high4;
   logic       ovf4;
   logic [2:0] dbg4;

   clk_div_monitor #(.CNT_W(4), .SYNC_STAGES(2)) u_dut4 (
      .clk        (clk),
      .rst        (rst),
      .start      (start4),
      .sig_in     (sig_in4),
      .busy       (busy4),
      .meas_valid (valid4),
      .meas_ready (ready4),
      .period     (period4),
      .high_time  (high4),
      .ovf        (ovf4),
      .dbg_state  (dbg4)
   );

   // ---------------- selected-instance view ----------------
   logic             sel4;
   logic             cur_valid;
   logic             cur_busy;
   logic [CNT_W-1:0] cur_period;
   logic [CNT_W-1:0] cur_high;
   logic             cur_ovf;
   logic [2:0]       cur_state;

   assign cur_valid  = sel4 ? valid4 : meas_valid;
   assign cur_busy   = sel4 ? busy4  : busy;
   assign cur_period = sel4 ? {12'd0, period4} : period;
   assign cur_high   = sel4 ? {12'd0, high4}   : high_time;
   assign cur_ovf    = sel4 ? ovf4   : ovf;
   assign cur_state  = sel4 ? dbg4   : dbg_state;

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // ---------------- sig_in pattern generators ----------------
   int pat_hi  = 3;
   int pat_lo  = 2;
   int pat4_hi = 20;
   int pat4_lo = 20;

   initial begin
      sig_in = 1'b0;
      forever begin
         if (pat_hi == 0) begin
            sig_in = 1'b0;
            @(negedge clk);
         end else begin
            sig_in = 1'b1;
            repeat (pat_hi) @(negedge clk);
            sig_in = 1'b0;
            repeat (pat_lo) @(negedge clk);
         end
      end
   end

   initial begin
      sig_in4 = 1'b0;
      forever begin
         if (pat4_hi == 0) begin
            sig_in4 = 1'b0;
            @(negedge clk);
         end else begin
            sig_in4 = 1'b1;
            repeat (pat4_hi) @(negedge clk);
            sig_in4 = 1'b0;
            repeat (pat4_lo) @(negedge clk);
         end
      end
   end

   // ---------------- driver: one full measurement ----------------
   task automatic run_meas(input bit use4, input logic [15:0] ep, input logic [15:0] eh,
                           input logic eo, input int hold, input bit poke);
      logic [W-1:0] e;
      int n;
      sel4 = use4;
      exp_q.push_back({ep, eh, eo});
      @(negedge clk);
      if (use4) start4 = 1'b1; else start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      start4 = 1'b0;
      check("busy_after_start", {31'd0, cur_busy}, 32'd1);
      n = 0;
      while (!cur_valid && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         check("valid_seen", 32'd0, 32'd1);
         e = exp_q.pop_front();
         return;
      end
      for (int i = 0; i < hold; i++) begin
         if (poke && i == hold / 2) begin
            if (use4) start4 = 1'b1; else start = 1'b1;
         end
         @(negedge clk);
         start  = 1'b0;
         start4 = 1'b0;
      end
      if (hold > 0) begin
         check("valid_held", {31'd0, cur_valid}, 32'd1);
         check("state_done", {29'd0, cur_state}, {29'd0, ST_DONE});
      end
      // transfer cycle; optionally collide a start with it
      if (use4) ready4 = 1'b1; else meas_ready = 1'b1;
      if (poke) begin
         if (use4) start4 = 1'b1; else start = 1'b1;
      end
      e = exp_q.pop_front();
      check("period",    {16'd0, cur_period}, {16'd0, e[W-1 -: CNT_W]});
      check("high_time", {16'd0, cur_high},   {16'd0, e[CNT_W:1]});
      check("ovf",       {31'd0, cur_ovf},    {31'd0, e[0]});
      @(negedge clk);
      meas_ready = 1'b0;
      ready4     = 1'b0;
      start      = 1'b0;
      start4     = 1'b0;
      check("valid_drop",     {31'd0, cur_valid}, 32'd0);
      check("idle_after_ack", {29'd0, cur_state}, {29'd0, ST_IDLE});
   endtask

   // ---------------- main sequence ----------------
   int nb;
   int nw;

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      start4     = 1'b0;
      meas_ready = 1'b0;
      ready4     = 1'b0;
      sel4       = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy",      {31'd0, busy},       32'd0);
      check("rst_valid",     {31'd0, meas_valid}, 32'd0);
      check("rst_period",    {16'd0, period},     32'd0);
      check("rst_high_time", {16'd0, high_time},  32'd0);
      check("rst_ovf",       {31'd0, ovf},        32'd0);
      check("rst_state",     {29'd0, dbg_state},  {29'd0, ST_IDLE});
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // 3 high / 2 low
      run_meas(1'b0, 16'd5, 16'd3, 1'b0, 4, 1'b0);

      // divide-by-4, start issued while sig_in is high
      pat_hi = 2;
      pat_lo = 2;
      repeat (20) @(negedge clk);
      @(posedge sig_in);
      run_meas(1'b0, 16'd4, 16'd2, 1'b0, 1, 1'b0);

      // long back-pressure with stray starts, including one on the transfer
      pat_hi = 3;
      pat_lo = 2;
      repeat (20) @(negedge clk);
      run_meas(1'b0, 16'd5, 16'd3, 1'b0, 10, 1'b1);

      // saturation on the 4-bit instance
      run_meas(1'b1, 16'd15, 16'd15, 1'b1, 2, 1'b0);

`ifdef CLK_DIV_MON_TIMEOUT_EN
      pat4_hi = 0;
      repeat (50) @(negedge clk);
      run_meas(1'b1, 16'd15, 16'd15, 1'b1, 0, 1'b0);
      pat4_hi = 20;
`else
      // stuck-low input: ARM waits without limit
      pat_hi = 0;
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nb = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy) nb++;
      end
      check("busy_stuck", nb, 32'd100);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("stuck_rst_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
      pat_hi = 3;
`endif

      // reset in the middle of the LOW phase
      sel4 = 1'b0;
      repeat (20) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nw = 0;
      while (dbg_state != ST_LOW && nw < 200) begin
         @(negedge clk);
         nw++;
      end
      check("reached_low", {29'd0, dbg_state}, {29'd0, ST_LOW});
      rst = 1'b1;
      #1;
      check("midrst_busy",      {31'd0, busy},       32'd0);
      check("midrst_valid",     {31'd0, meas_valid}, 32'd0);
      check("midrst_period",    {16'd0, period},     32'd0);
      check("midrst_high_time", {16'd0, high_time},  32'd0);
      check("midrst_ovf",       {31'd0, ovf},        32'd0);
      check("midrst_state",     {29'd0, dbg_state},  {29'd0, ST_IDLE});
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      run_meas(1'b0, 16'd5, 16'd3, 1'b0, 2, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
